// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button front-end.
package btn_pkg;

   localparam int BTN_DEBOUNCE_20MS = 1_000_000;
   localparam int BTN_REPEAT_DELAY  = 25_000_000;
   localparam int BTN_REPEAT_PERIOD = 5_000_000;

   localparam int BTN_UP     = 0;
   localparam int BTN_DOWN   = 1;
   localparam int BTN_SELECT = 2;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } rep_state_t;

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, debouncer, press/release pulses
// and hold-to-repeat pulse train.
//
// state | meaning
// IDLE  | no repeat activity; waiting for a press with repeat enabled
// HOLD  | button held with repeat enabled; rp_cnt paces repeat pulses
module button_channel
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_20MS,
   parameter int REPEAT_DELAY    = BTN_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = BTN_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic pressed_async,
   input  logic repeat_en,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeat_pulse,
   output logic press_next
);

   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RP_FIRE   = RW'(REPEAT_DELAY);
   // When REPEAT_PERIOD > REPEAT_DELAY this wraps negative; the counter wraps
   // the same way, so the distance to RP_FIRE is still REPEAT_PERIOD-1 steps.
   localparam logic [RW-1:0] RP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

   logic [1:0]    sync;
   logic [DW-1:0] db_cnt;
   logic          mismatch;
   logic          db_hit;
   logic          release_next;

   rep_state_t    state_q, state_d;
   logic [RW-1:0] rp_cnt, rp_cnt_d;
   logic          repeat_next;

   // Two-flop synchroniser for the asynchronous pin level.
   always_ff @(posedge clk) begin
      if (rst) sync <= '0;
      else     sync <= {sync[0], pressed_async};
   end

   assign mismatch     = (sync[1] != level);
   assign db_hit       = mismatch && (db_cnt == DB_LAST);
   assign press_next   = db_hit && !level;
   assign release_next = db_hit && level;

   // Debounce counter, debounced level and edge pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt        <= '0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         if (!mismatch || db_hit) db_cnt <= '0;
         else                     db_cnt <= db_cnt + DW'(1);
         if (db_hit) level <= ~level;
         press_pulse   <= press_next;
         release_pulse <= release_next;
      end
   end

   // Repeat FSM state, pacing counter and registered repeat pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rp_cnt       <= '0;
         repeat_pulse <= 1'b0;
      end else begin
         state_q      <= state_d;
         rp_cnt       <= rp_cnt_d;
         repeat_pulse <= repeat_next;
      end
   end

   // Repeat next-state: release or disable wins over a due repeat pulse.
   always_comb begin
      state_d     = state_q;
      rp_cnt_d    = rp_cnt;
      repeat_next = 1'b0;
      case (state_q)
         IDLE: begin
            if (press_next && repeat_en) begin
               state_d  = HOLD;
               rp_cnt_d = RW'(1);
            end
         end
         HOLD: begin
            if (release_next || !repeat_en) begin
               state_d  = IDLE;
               rp_cnt_d = '0;
            end else if (rp_cnt == RP_FIRE) begin
               repeat_next = 1'b1;
               rp_cnt_d    = RP_RELOAD;
            end else begin
               rp_cnt_d = rp_cnt + RW'(1);
            end
         end
         default: begin
            state_d  = IDLE;
            rp_cnt_d = '0;
         end
      endcase
   end

endmodule

// File: rtl/button_conditioner.sv
// Button front-end: polarity normalisation, one conditioning channel per
// button, and a registered any-press summary.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int N_BTN           = 3,
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_20MS,
   parameter int REPEAT_DELAY    = BTN_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = BTN_REPEAT_PERIOD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic [N_BTN-1:0] repeat_en,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeat,
   output logic             any_press
);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
      $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
   end
   if (REPEAT_DELAY < 1) begin : g_bad_rd
      $error("button_conditioner: REPEAT_DELAY must be >= 1");
   end
   if (REPEAT_PERIOD < 1) begin : g_bad_rp
      $error("button_conditioner: REPEAT_PERIOD must be >= 1");
   end

   localparam logic POL = (ACTIVE_LOW != 0);

   logic [N_BTN-1:0] pressed;
   logic [N_BTN-1:0] press_next;

   assign pressed = btn_raw ^ {N_BTN{POL}};

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .pressed_async (pressed[g]),
         .repeat_en     (repeat_en[g]),
         .level         (btn_level[g]),
         .press_pulse   (btn_press[g]),
         .release_pulse (btn_release[g]),
         .repeat_pulse  (btn_repeat[g]),
         .press_next    (press_next[g])
      );
   end

   // Summary press flag, registered alongside the per-channel press pulses.
   always_ff @(posedge clk) begin
      if (rst) any_press <= 1'b0;
      else     any_press <= |press_next;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios followed by random
// bouncing inputs, all compared every cycle against a cycle-level model.
module tb_button_conditioner;

   localparam int N  = 3;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] raw0 = '1;
   logic [N-1:0] raw1 = '0;
   logic [N-1:0] ren  = '0;

   logic [N-1:0] lvl0, prs0, rel0, rep0;
   logic [N-1:0] lvl1, prs1, rel1, rep1;
   logic         any0, any1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // model state per [dut][channel]
   bit m_h1 [2][N];
   bit m_h2 [2][N];
   bit m_lvl[2][N];
   bit m_hold[2][N];
   int m_run[2][N];
   int m_pt [2][N];
   bit e_prs[2][N];
   bit e_rel[2][N];
   bit e_rep[2][N];

   always #5 clk = ~clk;

   button_conditioner #(
      .N_BTN(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .rst(rst), .btn_raw(raw0), .repeat_en(ren),
      .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0),
      .btn_repeat(rep0), .any_press(any0)
   );

   button_conditioner #(
      .N_BTN(N), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut_ah (
      .clk(clk), .rst(rst), .btn_raw(raw1), .repeat_en(ren),
      .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1),
      .btn_repeat(rep1), .any_press(any1)
   );

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d observed %b expected %b", tag, cyc, obs, exp);
      end
   endtask

   // Spec-level model of one clock edge: the debouncer sees the pressed sense
   // two edges late; level flips after DB consecutive disagreeing cycles;
   // repeats fire at RD + k*RP cycles after the press that started a hold.
   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < N; i++) begin
            bit sense;
            bit seen;
            int el;
            sense = (d == 0) ? !raw0[i] : raw1[i];
            e_prs[d][i] = 1'b0;
            e_rel[d][i] = 1'b0;
            e_rep[d][i] = 1'b0;
            if (rst) begin
               m_h1[d][i] = 1'b0; m_h2[d][i] = 1'b0; m_lvl[d][i] = 1'b0;
               m_hold[d][i] = 1'b0; m_run[d][i] = 0;
            end else begin
               seen = m_h2[d][i];
               if (seen != m_lvl[d][i]) begin
                  m_run[d][i]++;
                  if (m_run[d][i] == DB) begin
                     m_lvl[d][i] = !m_lvl[d][i];
                     m_run[d][i] = 0;
                     if (m_lvl[d][i]) e_prs[d][i] = 1'b1;
                     else             e_rel[d][i] = 1'b1;
                  end
               end else begin
                  m_run[d][i] = 0;
               end
               if (m_hold[d][i]) begin
                  if (e_rel[d][i] || !ren[i]) m_hold[d][i] = 1'b0;
                  else begin
                     el = cyc - m_pt[d][i];
                     if (el >= RD && ((el - RD) % RP) == 0) e_rep[d][i] = 1'b1;
                  end
               end else if (e_prs[d][i] && ren[i]) begin
                  m_hold[d][i] = 1'b1;
                  m_pt[d][i]   = cyc;
               end
               m_h2[d][i] = m_h1[d][i];
               m_h1[d][i] = sense;
            end
         end
      end
   endtask

   function automatic logic [N-1:0] pack(input int d, input int kind);
      logic [N-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) begin
         case (kind)
            0:       v[i] = m_lvl[d][i];
            1:       v[i] = e_prs[d][i];
            2:       v[i] = e_rel[d][i];
            default: v[i] = e_rep[d][i];
         endcase
      end
      return v;
   endfunction

   task automatic compare_all();
      check("level_al",   lvl0, pack(0, 0));
      check("press_al",   prs0, pack(0, 1));
      check("release_al", rel0, pack(0, 2));
      check("repeat_al",  rep0, pack(0, 3));
      check("any_al",     {{(N-1){1'b0}}, any0}, {{(N-1){1'b0}}, |pack(0, 1)});
      check("level_ah",   lvl1, pack(1, 0));
      check("press_ah",   prs1, pack(1, 1));
      check("release_ah", rel1, pack(1, 2));
      check("repeat_ah",  rep1, pack(1, 3));
      check("any_ah",     {{(N-1){1'b0}}, any1}, {{(N-1){1'b0}}, |pack(1, 1)});
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic step_n(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      int reps;
      // reset
      rst = 1'b1; raw0 = '1; raw1 = '0; ren = '0;
      step_n(2);
      check("rst_level", lvl0, 3'b000);
      check("rst_press", prs0, 3'b000);
      check("rst_any",   {2'b00, any0}, 3'b000);
      rst = 1'b0;
      step_n(20);
      check("idle_level", lvl0, 3'b000);

      // clean press / release on ch0
      raw0[0] = 1'b0;
      step_n(5);
      check("press_early", prs0, 3'b000);
      step();
      check("press_edge6", prs0, 3'b001);
      check("any_edge6",   {2'b00, any0}, 3'b001);
      check("level_edge6", lvl0, 3'b001);
      step_n(24);
      raw0[0] = 1'b1;
      step_n(6);
      check("release_edge6", rel0, 3'b001);
      check("release_level", lvl0, 3'b000);
      step_n(5);

      // bounce on ch1: too short to register
      raw0[1] = 1'b0; step_n(3);
      raw0[1] = 1'b1; step_n(1);
      raw0[1] = 1'b0; step_n(3);
      raw0[1] = 1'b1; step_n(10);
      check("bounce_level", lvl0, 3'b000);

      // auto-repeat on ch2
      ren[2] = 1'b1;
      raw0[2] = 1'b0;
      step_n(6);
      check("rep_press", prs0, 3'b100);
      for (int k = 1; k <= 17; k++) begin
         step();
         check("rep_train", rep0 & 3'b100,
               ((k == RD) || (k == RD + RP) || (k == RD + 2*RP)) ? 3'b100 : 3'b000);
      end
      raw0[2] = 1'b1;
      reps = 0;
      for (int k = 0; k < 30; k++) begin
         step();
         if (k >= 6 && rep0[2]) reps++;
      end
      check("rep_after_rel", reps[N-1:0], 3'b000);

      // held with repeat disabled
      ren[2] = 1'b0;
      raw0[2] = 1'b0;
      reps = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (rep0[2]) reps++;
      end
      check("rep_disabled", reps[N-1:0], 3'b000);
      raw0[2] = 1'b1;
      step_n(10);

      // simultaneous press, reset mid-hold, press again after reset
      raw0 = 3'b000;
      step_n(6);
      check("simul_press", prs0, 3'b111);
      step_n(5);
      rst = 1'b1;
      step();
      check("midrst_level",   lvl0, 3'b000);
      check("midrst_release", rel0, 3'b000);
      rst = 1'b0;
      step_n(6);
      check("post_rst_press", prs0, 3'b111);
      raw0 = 3'b111;
      step_n(10);

      // active-high instance
      raw1[0] = 1'b1;
      step_n(6);
      check("ah_press", prs1, 3'b001);
      raw1[0] = 1'b0;
      step_n(6);
      check("ah_release", rel1, 3'b001);
      step_n(5);

      // random bouncing inputs, fast then slow
      for (int k = 0; k < 3000; k++) begin
         int tgl;
         tgl = (k < 1500) ? 5 : 24;
         rst = ($urandom_range(0, 499) == 0);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, tgl) == 0) raw0[i] = ~raw0[i];
            if ($urandom_range(0, tgl) == 0) raw1[i] = ~raw1[i];
            if ($urandom_range(0, 39) == 0)  ren[i]  = ~ren[i];
         end
         step();
      end
      rst = 1'b0;
      step_n(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
